// File: rtl/core_seq_pkg.sv
// rtl/core_seq_pkg.sv - opcodes, FSM states and instruction-word layout shared by the core sequencer
package core_seq_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD_W = 3'd1;
  localparam logic [2:0] OP_EXEC   = 3'd2;
  localparam logic [2:0] OP_ACC    = 3'd3;
  localparam logic [2:0] OP_FLUSH  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_XRD    = 3'd1,
    ST_XTAIL  = 3'd2,
    ST_L0RD   = 3'd3,
    ST_ACC    = 3'd4,
    ST_FLUSH  = 3'd5,
    ST_RETIRE = 3'd6
  } seq_state_e;

  // Fixed low-order control bits; the address fields sit above them.
  localparam int POS_LOAD     = 0;
  localparam int POS_EXECUTE  = 1;
  localparam int POS_L0_WR    = 2;
  localparam int POS_L0_RD    = 3;
  localparam int POS_OFIFO_RD = 6;
  localparam int POS_A_XMEM   = 7;

  function automatic int pos_wen_xmem(input int aw);
    return 7 + aw;
  endfunction

  function automatic int pos_cen_xmem(input int aw);
    return 8 + aw;
  endfunction

  function automatic int pos_a_pmem(input int aw);
    return 9 + aw;
  endfunction

  function automatic int pos_wen_pmem(input int aw);
    return 9 + 2 * aw;
  endfunction

  function automatic int pos_cen_pmem(input int aw);
    return 10 + 2 * aw;
  endfunction

  function automatic int pos_acc_en(input int aw);
    return 11 + 2 * aw;
  endfunction

  function automatic int pos_mode(input int aw);
    return 12 + 2 * aw;
  endfunction

  // Memory enables are active-low, so the quiet word has all four cen/wen bits set.
  function automatic logic [63:0] idle_inst(input int aw);
    logic [63:0] v;
    v = '0;
    v[pos_cen_pmem(aw)] = 1'b1;
    v[pos_wen_pmem(aw)] = 1'b1;
    v[pos_cen_xmem(aw)] = 1'b1;
    v[pos_wen_xmem(aw)] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/seq_cmd_fifo.sv
// rtl/seq_cmd_fifo.sv - synchronous command queue with full/empty flags and occupancy count
module seq_cmd_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_comb begin
    count   = wptr_q - rptr_q;
    full    = (count == PW'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + PW'(do_push);
    rptr_d  = rptr_q + PW'(do_pop);
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/core_inst_sequencer.sv
// rtl/core_inst_sequencer.sv - expands queued burst commands into per-cycle core instruction words
module core_inst_sequencer
  import core_seq_pkg::*;
#(
  parameter int  ADDR_W    = 11,
  parameter int  LEN_W     = 11,
  parameter int  CMD_DEPTH = 4,
  localparam int IW        = 2 * ADDR_W + 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic              cmd_mode,
  input  logic [ADDR_W-1:0] cmd_xaddr,
  input  logic [ADDR_W-1:0] cmd_paddr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              ofifo_valid,
  output logic [IW-1:0]     inst,
  output logic              busy,
  output logic              done
);

  localparam int CW    = 3 + 1 + 2 * ADDR_W + LEN_W;
  localparam int CNT_W = $clog2(CMD_DEPTH) + 1;
  localparam logic [IW-1:0] IDLE_INST = IW'(idle_inst(ADDR_W));

  localparam int P_WEN_X = pos_wen_xmem(ADDR_W);
  localparam int P_CEN_X = pos_cen_xmem(ADDR_W);
  localparam int P_A_P   = pos_a_pmem(ADDR_W);
  localparam int P_WEN_P = pos_wen_pmem(ADDR_W);
  localparam int P_CEN_P = pos_cen_pmem(ADDR_W);
  localparam int P_ACC   = pos_acc_en(ADDR_W);
  localparam int P_MODE  = pos_mode(ADDR_W);

  logic [CW-1:0]    fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0] fifo_count, count_next;

  seq_state_e        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] xaddr_q, xaddr_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  i_q, i_d, i_base;
  logic              acc_step;
  logic [IW-1:0]     inst_q, inst_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;

  seq_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({cmd_op, cmd_mode, cmd_xaddr, cmd_paddr, cmd_len}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // state_d names the phase whose word is shown next cycle; i_base is the word index it uses.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mode_d   = mode_q;
    xaddr_d  = xaddr_q;
    paddr_d  = paddr_q;
    len_d    = len_q;
    i_base   = i_q;
    acc_step = 1'b0;
    fifo_pop = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          {op_d, mode_d, xaddr_d, paddr_d, len_d} = fifo_rdata;
          i_base = '0;
          if (len_d == '0 || op_d == OP_NOP || op_d > OP_FLUSH) begin
            state_d = ST_RETIRE;
          end else if (op_d == OP_ACC) begin
            state_d = ST_ACC;
          end else if (op_d == OP_FLUSH) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_XRD;
          end
        end
      end
      ST_XRD: begin
        if (i_q == len_q) state_d = ST_XTAIL;
      end
      ST_XTAIL: begin
        state_d = ST_L0RD;
        i_base  = '0;
      end
      ST_L0RD, ST_FLUSH: begin
        if (i_q == len_q) state_d = ST_RETIRE;
      end
      ST_ACC: begin
        if (i_q == len_q) state_d = ST_RETIRE;
        else acc_step = ofifo_valid;
      end
      ST_RETIRE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    inst_d = IDLE_INST;
    i_d    = i_base;
    case (state_d)
      ST_XRD: begin
        inst_d[P_MODE]                 = mode_d;
        inst_d[P_CEN_X]                = 1'b0;
        inst_d[POS_A_XMEM +: ADDR_W]   = xaddr_d + ADDR_W'(i_base);
        inst_d[POS_L0_WR]              = (i_base != '0);
        i_d                            = i_base + 1'b1;
      end
      ST_XTAIL: begin
        inst_d[P_MODE]    = mode_d;
        inst_d[POS_L0_WR] = 1'b1;
      end
      ST_L0RD: begin
        inst_d[P_MODE]      = mode_d;
        inst_d[POS_L0_RD]   = 1'b1;
        inst_d[POS_LOAD]    = (op_d == OP_LOAD_W);
        inst_d[POS_EXECUTE] = (op_d == OP_EXEC);
        i_d                 = i_base + 1'b1;
      end
      ST_ACC: begin
        inst_d[P_MODE] = mode_d;
        if (acc_step) begin
          inst_d[P_ACC]              = 1'b1;
          inst_d[P_CEN_P]            = 1'b0;
          inst_d[P_WEN_P]            = 1'b0;
          inst_d[P_A_P +: ADDR_W]    = paddr_d + ADDR_W'(i_base);
          inst_d[POS_OFIFO_RD]       = 1'b1;
          i_d                        = i_base + 1'b1;
        end
      end
      ST_FLUSH: begin
        inst_d[P_MODE]           = 1'b1;
        inst_d[P_ACC]            = 1'b1;
        inst_d[P_CEN_P]          = 1'b0;
        inst_d[P_WEN_P]          = 1'b0;
        inst_d[P_A_P +: ADDR_W]  = paddr_d + ADDR_W'(i_base);
        i_d                      = i_base + 1'b1;
      end
      default: begin
      end
    endcase

    done_d     = (state_d == ST_RETIRE);
    count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    busy_d     = (state_d != ST_IDLE) || (count_next != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      mode_q  <= 1'b0;
      xaddr_q <= '0;
      paddr_q <= '0;
      len_q   <= '0;
      i_q     <= '0;
      inst_q  <= IDLE_INST;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      xaddr_q <= xaddr_d;
      paddr_q <= paddr_d;
      len_q   <= len_d;
      i_q     <= i_d;
      inst_q  <= inst_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign inst = inst_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: doc/core_inst_sequencer.md
Name: core_inst_sequencer

Overview:
- Micro-sequencer that expands queued burst commands into the per-cycle core instruction word.
- It sits between the testbench or host and the core, and replaces hand-scheduled inst streams.
- Supports WS kernel load, WS execute, WS psum accumulate and OS psum flush.
- Address width, and therefore instruction width, is parametrised.

Parameters:
- ADDR_W, 11: xmem/pmem address width; instruction width IW = 2*ADDR_W+13 (35 at default).
- LEN_W, 11: burst length width.
- CMD_DEPTH, 4: command queue depth, a power of 2 and at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue not full
- cmd_op  in  3  0 NOP, 1 LOAD_W, 2 EXEC, 3 ACC, 4 FLUSH; 5-7 are treated as NOP
- cmd_mode  in  1  mode bit for the command (0 WS, 1 OS)
- cmd_xaddr  in  ADDR_W  xmem base address
- cmd_paddr  in  ADDR_W  pmem base address
- cmd_len  in  LEN_W  number of words
- ofifo_valid  in  1  core OFIFO has a row available
- inst  out  IW  {mode, acc_en, cen_pmem, wen_pmem, a_pmem, cen_xmem, wen_xmem, a_xmem, ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, load}, MSB first
- busy  out  1  FSM not IDLE or queue non-empty
- done  out  1  one-cycle pulse when a command retires

Behaviour:
- All outputs are registered.
- IDLE_INST: cen_pmem=cen_xmem=wen_pmem=wen_xmem=1, all other bits 0. Memory enables are active-low.
- Reset: queue emptied, FSM to IDLE; inst=IDLE_INST, done=0, busy=0 on the cycle after reset is sampled; cmd_ready=1.
- Queue:
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready = !full, combinational from queue state. There is no bypass, so a push to a full queue is not accepted even if a pop occurs in the same cycle.
  - Commands are executed in FIFO order.
- FSM states: IDLE, XRD, XTAIL, L0RD, ACC, FLUSH, RETIRE.
- IDLE: if the queue is non-empty, pop into working registers (op, mode, xaddr, paddr, len) and clear index i.
  - len==0 or NOP goes straight to RETIRE.
  - LOAD_W/EXEC go to XRD.
  - ACC goes to ACC.
  - FLUSH goes to FLUSH.
  - The first active inst appears the cycle after the pop.
- XRD, len cycles: cen_xmem=0, wen_xmem=1, a_xmem=xaddr+i.
  - l0_wr is asserted one cycle behind each read to cover SRAM read latency 1.
  - After i==len-1, go to XTAIL.
- XTAIL, 1 cycle: l0_wr=1 for the last word, xmem disabled. Go to L0RD.
- L0RD, len cycles: l0_rd=1, plus load=1 (LOAD_W) or execute=1 (EXEC); mode=cmd_mode. Then go to RETIRE.
- ACC, per word i, stalls while ofifo_valid=0 (inst=IDLE_INST with mode held).
  - When ofifo_valid=1: one cycle of ofifo_rd=1, acc_en=1, cen_pmem=0, wen_pmem=0, a_pmem=paddr+i.
  - After len words, go to RETIRE.
- FLUSH, len cycles: mode=1 (forced), acc_en=1, cen_pmem=0, wen_pmem=0, a_pmem=paddr+i. Then go to RETIRE.
- RETIRE, 1 cycle: inst=IDLE_INST, done=1. Back to IDLE, which may pop the next command the same cycle RETIRE exits. Minimum gap between commands is 2 idle inst cycles.
- Address arithmetic is modulo 2^ADDR_W, so base+i wraps silently (2047+1 → 0).
- Index counter i is LEN_W wide.
- Bits ififo_wr and ififo_rd are always 0 in this generation.
- Reset mid-command aborts immediately: no done pulse, queued commands discarded.

Decomposition:
- Package core_seq_pkg:
  - opcode localparams OP_NOP..OP_FLUSH;
  - state enum;
  - inst bit-position functions of ADDR_W;
  - IDLE_INST constant builder.
- Sub-module seq_cmd_fifo: parametrised synchronous FIFO with width = 3+1+2*ADDR_W+LEN_W, depth CMD_DEPTH, full/empty flags.

Test Plan:
- Reset held 3 cycles, then released → inst=IDLE_INST (cen/wen bits 1, rest 0), busy=0, done=0, cmd_ready=1.
- LOAD_W xaddr=5 len=3 → exact inst sequence:
  - cycle 1: xmem reads at a_xmem=5;
  - cycle 2: a_xmem=6 with l0_wr=1;
  - cycle 3: a_xmem=7 with l0_wr=1;
  - cycle 4 (XTAIL): l0_wr=1 only;
  - cycles 5-7: l0_rd=1, load=1;
  - cycle 8: done=1.
- EXEC xaddr=2046 len=3 → a_xmem 2046, 2047, 0 (wrap); L0RD phase shows execute=1, load=0.
- ACC paddr=10 len=2, with ofifo_valid low 4 cycles, high 1, low 2, high 1 → exactly 2 write cycles (a_pmem=10, 11, acc_en=1, ofifo_rd=1), none during stalls, done after the second write.
- Push 5 FLUSH commands back-to-back with CMD_DEPTH=4 while the FSM is busy → cmd_ready drops after the 4th accepted push. All accepted commands then complete in order, each with mode=1, and there are exactly 4 done pulses.
- Reset asserted mid-XRD of EXEC len=8 → next cycle inst=IDLE_INST, busy=0, no done pulse; the queued command is not executed.
